// File: rtl/muldiv_seq_if.sv
// Operand/result bundle between the ID/EX stage and the multi-cycle MULT/DIV sequencer.
// Handshake: start is a request pulse taken only when the sequencer is IDLE or DONE.
// busy doubles as the pipeline stall, and done is a one-cycle "hi/lo valid" strobe.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, A, B, flush,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, A, B, flush,
        output busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that writes HI/LO (shift-add / restoring divide).
// Optional MULDIV_EARLY_OUT_EN: multiplies finish early once the remaining multiplier bits are zero.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_seq_if.slave   bus,
    output logic [1:0]    dbg_state
);
    localparam int CW = $clog2(WIDTH);
    localparam int W2 = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  mplr_q, mplr_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic              is_div_q, is_div_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              div_zero_q, div_zero_d;

    logic              accept;
    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    add_term;
    logic [WIDTH:0]    sum;
    logic [W2-1:0]     shifted;
    logic [WIDTH:0]    rem_sh;
    logic              sub_ok;
    logic [W2-1:0]     prod;
    logic [W2-1:0]     prod_fix;

`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0]  mrem_q, mrem_d;
    logic [WIDTH-1:0]  mrem_nx;
    logic [CW-1:0]     rem_cnt;
    logic [W2-1:0]     early_prod;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mplr_d     = mplr_q;
        opnd_d     = opnd_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        is_div_d   = is_div_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;

        // op[0]=0 selects the signed flavours (MULT, DIV)
        a_neg  = ~bus.op[0] & bus.A[WIDTH-1];
        b_neg  = ~bus.op[0] & bus.B[WIDTH-1];
        a_mag  = a_neg ? -bus.A : bus.A;
        b_mag  = b_neg ? -bus.B : bus.B;
        accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start && !bus.flush;

        // Multiply step: carry of the accumulator add is kept and shifted back in.
        add_term = mplr_q[0] ? {1'b0, opnd_q} : '0;
        sum      = {1'b0, acc_q} + add_term;
        shifted  = {sum, mplr_q[WIDTH-1:1]};

        // Divide step: acc holds the partial remainder, mplr the dividend/quotient.
        rem_sh = {acc_q, mplr_q[WIDTH-1]};
        sub_ok = rem_sh >= {1'b0, opnd_q};

        prod     = {acc_q, mplr_q};
        prod_fix = (sa_q ^ sb_q) ? -prod : prod;

`ifdef MULDIV_EARLY_OUT_EN
        mrem_d     = mrem_q;
        mrem_nx    = mrem_q >> 1;
        rem_cnt    = LAST - cnt_q;
        early_prod = shifted >> rem_cnt;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    div_zero_d = 1'b0;
                    sa_d       = a_neg;
                    sb_d       = b_neg;
                    is_div_d   = bus.op[1];
                    cnt_d      = '0;
                    acc_d      = '0;
                    state_d    = S_CALC;
                    if (bus.op[1]) begin
                        opnd_d = b_mag;
                        mplr_d = a_mag;
                        if (bus.B == '0) begin
                            hi_d       = bus.A;
                            lo_d       = '1;
                            div_zero_d = 1'b1;
                            state_d    = S_DONE;
                        end
                    end else begin
                        opnd_d = a_mag;
                        mplr_d = b_mag;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    mrem_d = b_mag;
`endif
                end
            end

            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (is_div_q) begin
                        mplr_d = {mplr_q[WIDTH-2:0], sub_ok};
                        acc_d  = sub_ok ? WIDTH'(rem_sh - {1'b0, opnd_q}) : rem_sh[WIDTH-1:0];
                    end else begin
                        acc_d  = shifted[W2-1:WIDTH];
                        mplr_d = shifted[WIDTH-1:0];
                    end
                    if (cnt_q == LAST) begin
                        state_d = S_FIX;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    // Remaining multiplier bits all zero: the rest is pure shifting.
                    if (!is_div_q) begin
                        mrem_d = mrem_nx;
                        if (mrem_nx == '0) begin
                            acc_d   = early_prod[W2-1:WIDTH];
                            mplr_d  = early_prod[WIDTH-1:0];
                            state_d = S_FIX;
                        end
                    end
`endif
                end
            end

            S_FIX: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        hi_d = sa_q ? -acc_q : acc_q;
                        lo_d = (sa_q ^ sb_q) ? -mplr_q : mplr_q;
                    end else begin
                        hi_d = prod_fix[W2-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    state_d = S_DONE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mplr_q     <= '0;
            opnd_q     <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            is_div_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mplr_q     <= mplr_d;
            opnd_q     <= opnd_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            is_div_q   <= is_div_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mrem_q <= '0;
        end else begin
            mrem_q <= mrem_d;
        end
    end
`endif

    assign bus.busy     = (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.done     = (state_q == S_DONE);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.div_zero = div_zero_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: table of directed vectors, random vectors checked against an arithmetic
// model, plus hand sequences for flush, flush+start, start-while-busy and mid-operation reset.
module tb_muldiv_seq;
  localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int FLUSH_EDGES = 1;
`else
  localparam int FLUSH_EDGES = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  muldiv_seq_if #(.WIDTH(W)) bus ();
  muldiv_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  logic [2*W:0] exp_q[$];
  int           lat_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           n_chk = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;
  logic         last_dz = 1'b0;
  vec_t         tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dz = dz;
    return v;
  endfunction

  // Reference arithmetic: {div_zero, hi, lo}
  function automatic logic [2*W:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (op == 2'b00) begin
      p = sa * sb;
      return {1'b0, p};
    end
    if (op == 2'b01) begin
      p = ua * ub;
      return {1'b0, p};
    end
    if (b == '0) return {1'b1, a, 32'hFFFF_FFFF};
    if (op == 2'b10) begin
      q = sa / sb;
      r = sa % sb;
      return {1'b0, r[31:0], q[31:0]};
    end
    q = ua / ub;
    r = ua % ub;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  function automatic int exp_latency(input logic [1:0] op, input logic [W-1:0] b);
    logic [W-1:0] m;
    int h;
    if (op[1]) return (b == '0) ? 1 : W + 2;
    m = (op == 2'b00 && b[W-1]) ? -b : b;
    h = 0;
    for (int i = 0; i < W; i++) if (m[i]) h = i;
`ifdef MULDIV_EARLY_OUT_EN
    return h + 3;
`else
    return (h >= 0) ? W + 2 : 0;
`endif
  endfunction

  // Called at a sample point (#1 after an edge) with the DUT in IDLE or DONE.
  task automatic apply(input vec_t v);
    logic [2*W:0] e;
    int el, lat, busy_n;
    bus.start = 1'b1; bus.op = v.op; bus.A = v.a; bus.B = v.b;
    exp_q.push_back({v.dz, v.hi, v.lo});
    lat_q.push_back(exp_latency(v.op, v.b));
    n_vec++;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
    check("div_zero_after_start", 64'(bus.div_zero), 64'(v.dz));
    lat = 1; busy_n = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_n++;
      bus.start = bus.busy && ($urandom_range(0, 7) == 0);
      bus.op = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    e = exp_q.pop_front();
    el = lat_q.pop_front();
    if (!bus.done) begin
      check("done_timeout", 64'(0), 64'(1));
      return;
    end
    check("hi", 64'(bus.hi), 64'(e[2*W-1:W]));
    check("lo", 64'(bus.lo), 64'(e[W-1:0]));
    check("div_zero", 64'(bus.div_zero), 64'(e[2*W]));
    check("latency", 64'(lat), 64'(el));
    check("busy_cycles", 64'(busy_n), 64'(el - 1));
    check("busy_in_done", 64'(bus.busy), 64'(0));
    last_hi = e[2*W-1:W]; last_lo = e[W-1:0]; last_dz = e[2*W];
  endtask

  initial begin
    vec_t v;
    logic [2*W:0] m;
    int gap;

    tbl[0]  = mk(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    tbl[1]  = mk(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    tbl[2]  = mk(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    tbl[3]  = mk(2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    tbl[4]  = mk(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    tbl[5]  = mk(2'b01, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b0);
    tbl[6]  = mk(2'b00, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 32'h0000_001E, 1'b0);
    tbl[7]  = mk(2'b11, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999, 1'b0);
    tbl[8]  = mk(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    tbl[9]  = mk(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    tbl[10] = mk(2'b10, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);

    bus.start = 1'b0; bus.op = 2'b00; bus.A = '0; bus.B = '0; bus.flush = 1'b0;

    // Clock/reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_hi", 64'(bus.hi), 64'(0));
    check("rst_lo", 64'(bus.lo), 64'(0));
    check("rst_div_zero", 64'(bus.div_zero), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table, issued back-to-back in each DONE cycle
    for (int i = 0; i < 11; i++) apply(tbl[i]);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(bus.done), 64'(0));

    // Random vectors against the model, with random idle gaps
    for (int i = 0; i < 14; i++) begin
      v.op = 2'($urandom_range(0, 3));
      v.a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      v.b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
             ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 40)) : $urandom;
      m = model(v.op, v.a, v.b);
      v.dz = m[2*W]; v.hi = m[2*W-1:W]; v.lo = m[W-1:0];
      apply(v);
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;

    // Flush mid-operation: no done, results unchanged
    bus.start = 1'b1; bus.op = 2'b00; bus.A = 32'd5; bus.B = 32'd6;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (FLUSH_EDGES) begin @(posedge clk); #1; end
    check("busy_before_flush", 64'(bus.busy), 64'(1));
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'(0));
    check("flush_done", 64'(bus.done), 64'(0));
    check("flush_hi", 64'(bus.hi), 64'(last_hi));
    check("flush_lo", 64'(bus.lo), 64'(last_lo));
    check("flush_div_zero", 64'(bus.div_zero), 64'(last_dz));
    @(posedge clk); #1;
    check("flush_no_late_done", 64'(bus.done), 64'(0));

    // flush and start together in IDLE: start ignored
    bus.flush = 1'b1; bus.start = 1'b1; bus.op = 2'b01; bus.A = 32'd3; bus.B = 32'd5;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0;
    check("flush_start_busy", 64'(bus.busy), 64'(0));
    check("flush_start_done", 64'(bus.done), 64'(0));

    // Next start is accepted normally
    apply(mk(2'b00, 32'd5, 32'd6, 32'h0, 32'd30, 1'b0));
    @(posedge clk); #1;

    // Asynchronous reset mid-operation
    bus.start = 1'b1; bus.op = 2'b01; bus.A = 32'hFFFF_FFFF; bus.B = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_done", 64'(bus.done), 64'(0));
    check("midrst_hi", 64'(bus.hi), 64'(0));
    check("midrst_lo", 64'(bus.lo), 64'(0));
    check("midrst_div_zero", 64'(bus.div_zero), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    apply(mk(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
